// File: rtl/sobel_pkg.sv
// Shared constants, packer FSM states and byte-slot ordering for the Sobel
// custom-instruction datapath (packer and line-buffer engine).
package sobel_pkg;

  localparam int unsigned PIX_W          = 8;
  localparam int unsigned PIX_PER_WORD   = 8;
  localparam int unsigned MAX_LINE_WIDTH = 64;
  localparam int unsigned COL_IDX_W      = 7;
  localparam int unsigned WORD_W         = PIX_W * PIX_PER_WORD;
  localparam int unsigned HALF_W         = WORD_W / 2;
  localparam int unsigned SLOT_W         = $clog2(PIX_PER_WORD);

  typedef enum logic {
    S_FILL,
    S_WAIT
  } pack_state_e;

  // Pixel 0 sits in the least-significant byte; the engine unpacks with slot_lsb() too.
  localparam bit SLOT_LSB_FIRST = 1'b1;

  function automatic int unsigned slot_lsb(input logic [SLOT_W-1:0] slot);
    int unsigned s;
    s = 32'(slot);
    if (SLOT_LSB_FIRST) return s * PIX_W;
    return (PIX_PER_WORD - 1 - s) * PIX_W;
  endfunction

endpackage

// File: rtl/sobel_pack_word_buf.sv
// Output word register of the Sobel pixel packer: data plus column/line/frame
// tags behind a valid/ready handshake.
module sobel_pack_word_buf
  import sobel_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_load,
  input  logic [WORD_W-1:0]    i_data,
  input  logic [COL_IDX_W-1:0] i_col,
  input  logic                 i_sol,
  input  logic                 i_eol,
  input  logic                 i_eof,
  input  logic                 i_ready,
  output logic                 o_valid,
  output logic [HALF_W-1:0]    o_dataa,
  output logic [HALF_W-1:0]    o_datab,
  output logic [COL_IDX_W-1:0] o_col,
  output logic                 o_sol,
  output logic                 o_eol,
  output logic                 o_eof
);

  logic                 r_valid;
  logic [HALF_W-1:0]    r_dataa;
  logic [HALF_W-1:0]    r_datab;
  logic [COL_IDX_W-1:0] r_col;
  logic                 r_sol;
  logic                 r_eol;
  logic                 r_eof;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_dataa <= '0;
      r_datab <= '0;
      r_col   <= '0;
      r_sol   <= 1'b0;
      r_eol   <= 1'b0;
      r_eof   <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_dataa <= i_data[HALF_W-1:0];
      r_datab <= i_data[WORD_W-1:HALF_W];
      r_col   <= i_col;
      r_sol   <= i_sol;
      r_eol   <= i_eol;
      r_eof   <= i_eof;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_dataa = r_dataa;
  assign o_datab = r_datab;
  assign o_col   = r_col;
  assign o_sol   = r_sol;
  assign o_eol   = r_eol;
  assign o_eof   = r_eof;

endmodule

// File: rtl/sobel_pixel_packer.sv
// Packs a byte-serial pixel stream into tagged 64-bit dataa/datab words.
// Optional SOBEL_PACK_STATS_EN adds frame_count and drop_count outputs.
module sobel_pixel_packer
  import sobel_pkg::*;
#(
  parameter int unsigned LINE_WIDTH = 64,
  parameter int unsigned NUM_LINES  = 64
)(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 frame_start,
  input  logic [PIX_W-1:0]     pix_in,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  output logic [HALF_W-1:0]    dataa,
  output logic [HALF_W-1:0]    datab,
  output logic                 word_valid,
  input  logic                 word_ready,
  output logic [COL_IDX_W-1:0] col_index,
  output logic                 sol,
  output logic                 eol,
  output logic                 eof
`ifdef SOBEL_PACK_STATS_EN
  ,
  output logic [15:0]          frame_count,
  output logic [15:0]          drop_count
`endif
);

  localparam int unsigned WORDS_PER_LINE = LINE_WIDTH / PIX_PER_WORD;
  localparam int unsigned WCOL_W         = $clog2(MAX_LINE_WIDTH / PIX_PER_WORD);
  localparam int unsigned LINE_W         = $clog2(NUM_LINES);

  if ((LINE_WIDTH % PIX_PER_WORD) != 0 || LINE_WIDTH == 0 || LINE_WIDTH > MAX_LINE_WIDTH) begin : g_bad_width
    $error("sobel_pixel_packer: LINE_WIDTH must be a nonzero multiple of 8 not above 64");
  end
  if (NUM_LINES < 3) begin : g_bad_lines
    $error("sobel_pixel_packer: NUM_LINES must be at least 3");
  end

  pack_state_e         r_state;
  pack_state_e         w_state_nxt;
  logic [SLOT_W-1:0]   r_byte_cnt;
  logic [SLOT_W-1:0]   w_byte_cnt_nxt;
  logic [SLOT_W-1:0]   w_slot;
  logic [WORD_W-1:0]   r_asm;
  logic [WORD_W-1:0]   w_asm_nxt;
  logic [WORD_W-1:0]   w_load_data;
  logic [WCOL_W-1:0]   r_word_col;
  logic [LINE_W-1:0]   r_line_cnt;
  logic                r_run;
  logic                w_pix_xfer;
  logic                w_word_xfer;
  logic                w_buf_free;
  logic                w_load;
  logic                w_tag_eol;
  logic                w_tag_eof;

  // frame_start opens the input even from S_WAIT so its pixel becomes slot 0.
  assign pix_ready   = r_run && (r_state == S_FILL || frame_start);
  assign w_pix_xfer  = pix_valid && pix_ready;
  assign w_word_xfer = word_valid && word_ready;
  assign w_buf_free  = !word_valid || word_ready;
  assign w_tag_eol   = (r_word_col == WCOL_W'(WORDS_PER_LINE - 1));
  assign w_tag_eof   = w_tag_eol && (r_line_cnt == LINE_W'(NUM_LINES - 1));

  always_comb begin
    w_state_nxt    = r_state;
    w_byte_cnt_nxt = r_byte_cnt;
    w_asm_nxt      = r_asm;
    w_load         = 1'b0;
    w_load_data    = r_asm;
    w_slot         = frame_start ? '0 : r_byte_cnt;

    if (frame_start) begin
      w_state_nxt    = S_FILL;
      w_byte_cnt_nxt = '0;
    end
    if (w_pix_xfer) begin
      for (int unsigned s = 0; s < PIX_PER_WORD; s++) begin
        if (w_slot == SLOT_W'(s)) w_asm_nxt[slot_lsb(SLOT_W'(s)) +: PIX_W] = pix_in;
      end
      w_byte_cnt_nxt = w_slot + SLOT_W'(1);
    end

    if (!frame_start) begin
      case (r_state)
        S_FILL: begin
          if (w_pix_xfer && r_byte_cnt == SLOT_W'(PIX_PER_WORD - 1)) begin
            if (w_buf_free) begin
              w_load      = 1'b1;
              w_load_data = w_asm_nxt;
            end else begin
              w_state_nxt = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (w_word_xfer) begin
            w_load      = 1'b1;
            w_state_nxt = S_FILL;
          end
        end
        default: w_state_nxt = S_FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_FILL;
      r_byte_cnt <= '0;
      r_asm      <= '0;
      r_word_col <= '0;
      r_line_cnt <= '0;
      r_run      <= 1'b0;
    end else begin
      r_run      <= 1'b1;
      r_state    <= w_state_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_asm      <= w_asm_nxt;
      if (frame_start) begin
        r_word_col <= '0;
        r_line_cnt <= '0;
      end else if (w_load) begin
        if (w_tag_eol) begin
          r_word_col <= '0;
          r_line_cnt <= w_tag_eof ? '0 : r_line_cnt + LINE_W'(1);
        end else begin
          r_word_col <= r_word_col + WCOL_W'(1);
        end
      end
    end
  end

  sobel_pack_word_buf u_word_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_load),
    .i_data  (w_load_data),
    .i_col   (COL_IDX_W'({r_word_col, {SLOT_W{1'b0}}})),
    .i_sol   (r_word_col == '0),
    .i_eol   (w_tag_eol),
    .i_eof   (w_tag_eof),
    .i_ready (word_ready),
    .o_valid (word_valid),
    .o_dataa (dataa),
    .o_datab (datab),
    .o_col   (col_index),
    .o_sol   (sol),
    .o_eol   (eol),
    .o_eof   (eof)
  );

`ifdef SOBEL_PACK_STATS_EN
  logic [15:0] r_frame_count;
  logic [15:0] r_drop_count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_frame_count <= '0;
      r_drop_count  <= '0;
    end else begin
      if (w_word_xfer && eof) r_frame_count <= r_frame_count + 16'd1;
      if (frame_start && (r_byte_cnt != '0 || r_state == S_WAIT) && r_drop_count != '1)
        r_drop_count <= r_drop_count + 16'd1;
    end
  end

  assign frame_count = r_frame_count;
  assign drop_count  = r_drop_count;
`endif

endmodule

// File: tb/tb_sobel_pixel_packer.sv
// Self-checking bench for sobel_pixel_packer: directed phases plus random
// traffic against a queue-based model of pixels, words and buffer capacity.
module tb_sobel_pixel_packer;

  localparam int unsigned LW  = 64;
  localparam int unsigned NL  = 3;
  localparam int unsigned WPL = LW / 8;
  localparam int unsigned WPF = WPL * NL;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        frame_start;
  logic [7:0]  pix_in;
  logic        pix_valid;
  logic        pix_ready;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic        word_valid;
  logic        word_ready;
  logic [6:0]  col_index;
  logic        sol;
  logic        eol;
  logic        eof;
`ifdef SOBEL_PACK_STATS_EN
  logic [15:0] frame_count;
  logic [15:0] drop_count;
`endif

  always #5 clk = ~clk;

  sobel_pixel_packer #(.LINE_WIDTH(LW), .NUM_LINES(NL)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .pix_in      (pix_in),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .dataa       (dataa),
    .datab       (datab),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .col_index   (col_index),
    .sol         (sol),
    .eol         (eol),
    .eof         (eof)
`ifdef SOBEL_PACK_STATS_EN
    ,
    .frame_count (frame_count),
    .drop_count  (drop_count)
`endif
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [6:0]  col;
    logic        sol;
    logic        eol;
    logic        eof;
  } word_t;

  // m_q holds words the packer owes the consumer: [0] is in the output
  // register, a second entry is the complete word waiting behind it.
  word_t       m_q[$];
  logic [7:0]  m_pend[$];
  int unsigned m_widx;
  logic        m_run;
  int unsigned m_frames;
  int unsigned m_drops;

  int total = 0;
  int bad   = 0;
  int unsigned px_cnt, xfer_cnt, eof_seen, eof_idx;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic word_t make_word();
    word_t w;
    int unsigned c;
    c     = m_widx % WPL;
    w.a   = {m_pend[3], m_pend[2], m_pend[1], m_pend[0]};
    w.b   = {m_pend[7], m_pend[6], m_pend[5], m_pend[4]};
    w.col = 7'(c * 8);
    w.sol = (c == 0);
    w.eol = (c == WPL - 1);
    w.eof = (m_widx == WPF - 1);
    return w;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pend.delete();
    m_widx   = 0;
    m_run    = 1'b0;
    m_frames = 0;
    m_drops  = 0;
  endtask

  // One clock: check outputs at the falling edge, then advance the model on the rising edge.
  task automatic step();
    logic pxfer, wxfer, drop;
    @(negedge clk);
    chk("pix_ready", pix_ready, m_run && (frame_start || m_q.size() < 2));
    chk("word_valid", word_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      chk("dataa", dataa, m_q[0].a);
      chk("datab", datab, m_q[0].b);
      chk("col_index", col_index, m_q[0].col);
      chk("sol", sol, m_q[0].sol);
      chk("eol", eol, m_q[0].eol);
      chk("eof", eof, m_q[0].eof);
    end
    pxfer = pix_valid && pix_ready;
    wxfer = word_valid && word_ready;
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else begin
      m_run = 1'b1;
      if (frame_start) begin
        drop = (m_pend.size() != 0) || (m_q.size() == 2);
        if (m_q.size() == 2) void'(m_q.pop_back());
        m_pend.delete();
        m_widx = 0;
        if (drop && m_drops < 16'hFFFF) m_drops++;
      end
      if (wxfer && m_q.size() != 0) begin
        if (m_q[0].eof) begin
          m_frames = (m_frames + 1) % 65536;
          eof_seen++;
          eof_idx = xfer_cnt;
        end
        void'(m_q.pop_front());
        xfer_cnt++;
      end
      if (pxfer) begin
        px_cnt++;
        m_pend.push_back(pix_in);
        if (m_pend.size() == 8) begin
          m_q.push_back(make_word());
          m_pend.delete();
          m_widx = (m_widx + 1) % WPF;
        end
      end
    end
    #1;
  endtask

  initial begin
    reset_n     = 1'b0;
    frame_start = 1'b0;
    pix_valid   = 1'b0;
    pix_in      = '0;
    word_ready  = 1'b0;
    px_cnt = 0; xfer_cnt = 0; eof_seen = 0; eof_idx = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_word_valid", word_valid, 0);
    chk("rst_dataa", dataa, 0);
    chk("rst_datab", datab, 0);
    chk("rst_col", col_index, 0);
    chk("rst_sol", sol, 0);
    chk("rst_eol", eol, 0);
    chk("rst_eof", eof, 0);
    chk("rst_pix_ready", pix_ready, 0);
    reset_n = 1'b1;
    step();

    // Continuous ramp with the consumer always ready.
    word_ready = 1'b1;
    pix_valid  = 1'b1;
    for (int i = 0; i < 64; i++) begin
      pix_in = 8'(i);
      step();
      if (i == 7) begin
        chk("w0_valid", word_valid, 1);
        chk("w0_dataa", dataa, 32'h03020100);
        chk("w0_datab", datab, 32'h07060504);
        chk("w0_col", col_index, 0);
        chk("w0_sol", sol, 1);
      end
    end
    chk("w7_dataa", dataa, 32'h3B3A3938);
    chk("w7_col", col_index, 56);
    chk("w7_eol", eol, 1);
    chk("ramp_px_cnt", px_cnt, 64);

    // Back-pressure from an empty output register.
    pix_valid = 1'b0;
    step();
    word_ready = 1'b0;
    pix_valid  = 1'b1;
    px_cnt = 0;
    repeat (20) begin
      pix_in = 8'($urandom);
      step();
    end
    chk("bp_px_cnt", px_cnt, 16);
    chk("bp_pix_ready", pix_ready, 0);
    word_ready = 1'b1;
    repeat (24) begin
      pix_in = 8'($urandom);
      step();
    end

    // Full frame from a clean frame_start.
    pix_valid = 1'b0;
    repeat (2) step();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    xfer_cnt = 0; eof_seen = 0;
    pix_valid = 1'b1;
    repeat (200) begin
      pix_in = 8'($urandom);
      step();
    end
    pix_valid = 1'b0;
    repeat (2) step();
    chk("frame_eof_count", eof_seen, 1);
    chk("frame_eof_index", eof_idx, WPF - 1);

    // frame_start discards a partial word; its own pixel becomes pixel 0.
    pix_valid = 1'b1;
    repeat (5) begin
      pix_in = 8'($urandom);
      step();
    end
    frame_start = 1'b1;
    pix_in      = 8'hAA;
    step();
    frame_start = 1'b0;
    repeat (7) begin
      pix_in = 8'($urandom);
      step();
    end
    chk("fs_valid", word_valid, 1);
    chk("fs_pix0", dataa[7:0], 8'hAA);
    chk("fs_col", col_index, 0);
    chk("fs_sol", sol, 1);
`ifdef SOBEL_PACK_STATS_EN
    chk("fs_drop_count", drop_count, m_drops);
`endif

    // Random traffic with occasional frame_start pulses.
    for (int i = 0; i < 800; i++) begin
      pix_in      = 8'($urandom);
      pix_valid   = ($urandom_range(0, 9) < 8);
      word_ready  = ($urandom_range(0, 9) < 7);
      frame_start = ($urandom_range(0, 199) == 0);
      step();
    end
    frame_start = 1'b0;

    // Reset while a word is held in the output register.
    word_ready = 1'b0;
    pix_valid  = 1'b1;
    for (int i = 0; i < 20 && !word_valid; i++) begin
      pix_in = 8'($urandom);
      step();
    end
    chk("pre_reset_valid", word_valid, 1);
    reset_n = 1'b0;
    step();
    chk("mid_rst_valid", word_valid, 0);
    chk("mid_rst_pix_ready", pix_ready, 0);
    reset_n    = 1'b1;
    word_ready = 1'b1;
    repeat (9) begin
      pix_in = 8'($urandom);
      step();
    end
    chk("post_rst_valid", word_valid, 1);
    chk("post_rst_col", col_index, 0);
    chk("post_rst_sol", sol, 1);
    pix_valid = 1'b0;
    repeat (3) step();

`ifdef SOBEL_PACK_STATS_EN
    chk("frame_count", frame_count, m_frames);
    chk("drop_count", drop_count, m_drops);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sobel_pixel_packer.md
Name: sobel_pixel_packer

Overview:
- Writer side of the Sobel custom-instruction datapath.
- Takes a byte-serial 8-bit grayscale pixel stream and packs 8 consecutive pixels into the dataa/datab operand pair consumed by the Sobel line-buffer engine.
- Tags each word with its column offset and with line and frame markers.
- Double-buffered, so a sustained 1 pixel/clk input runs without stalls while the consumer accepts one word per 8 clocks.

Parameters:
- LINE_WIDTH, 64: pixels per line. Must be a multiple of 8 and at most 64 (the engine's line buffer is 512 bits). Any other value is an elaboration error.
- NUM_LINES, 64: lines per frame, at least 3.

Ports:
- clk, in, 1: single clock, rising edge.
- reset_n, in, 1: synchronous reset, active-low.
- frame_start, in, 1: one-cycle pulse that resynchronises to a new frame.
- pix_in, in, 8: input pixel.
- pix_valid, in, 1: pix_in is valid.
- pix_ready, out, 1: the packer accepts pix_in this cycle.
- dataa, out, 32: pixels 0..3 of the word; pixel 0 in [7:0], pixel 3 in [31:24].
- datab, out, 32: pixels 4..7 of the word; pixel 4 in [7:0], pixel 7 in [31:24].
- word_valid, out, 1: the output word is valid.
- word_ready, in, 1: the consumer takes the word this cycle.
- col_index, out, 7: pixel offset of pixel 0 within the line (0, 8, ..., LINE_WIDTH-8).
- sol, out, 1: word is the first of its line.
- eol, out, 1: word is the last of its line.
- eof, out, 1: word is the last of the frame.

Behaviour:
- Reset, sampled on a clk edge while reset_n=0, sets: word_valid=0, dataa=datab=0, col_index=0, sol/eol/eof=0, pix_ready=0. Internal counters and state are cleared. pix_ready rises the cycle after reset_n=1.
- Pixel transfer: occurs when pix_valid && pix_ready. Word transfer: occurs when word_valid && word_ready.
- Assembly register: 64 bits with a byte counter byte_cnt (0..7). An accepted pixel goes into byte slot byte_cnt, and byte_cnt increments.
- FSM, S_FILL:
  - pix_ready=1.
  - On the 8th pixel (byte_cnt=7 accepted), if the output buffer is empty or drains this same cycle, the complete word moves to the output on the next edge, word_valid=1, and the FSM stays in S_FILL with byte_cnt=0.
  - Otherwise go to S_WAIT.
- FSM, S_WAIT:
  - pix_ready=0; the assembly register is full.
  - On a word transfer, the assembled word moves to the output on the same edge, word_valid stays 1, and the FSM returns to S_FILL.
- Output latency: the 8th pixel accepted at edge N appears on dataa/datab at N+1.
- The output word and tags hold stable while word_valid && !word_ready.
- Tags are computed at the load into the output register:
  - col_index = word_col*8.
  - sol = (word_col==0).
  - eol = (word_col==LINE_WIDTH/8-1).
  - eof = eol && (line_cnt==NUM_LINES-1).
- Counter wrap:
  - word_col wraps 0 after eol, and line_cnt increments.
  - line_cnt wraps 0 after eof. The next frame starts automatically with no frame_start required.
- A simultaneous load and word transfer in one cycle is legal, with no bubble.
- frame_start:
  - Discards any partial assembly (byte_cnt=0) and any word in S_WAIT.
  - Clears word_col and line_cnt, and forces the FSM to S_FILL.
  - A word already in the output register stays valid until taken.
  - A pixel presented in the same cycle as frame_start is accepted as pixel 0 of the new frame.
- reset_n low mid-word or mid-frame aborts everything, with the values listed above.
- Arithmetic is unsigned with no saturation. Pixels pass through bit-exact.

Optional Feature:
- Macro: SOBEL_PACK_STATS_EN.
- Defined:
  - Adds output frame_count[15:0], which increments at each word transfer with eof=1 and wraps at 0xFFFF to 0.
  - Adds output drop_count[15:0], which increments when frame_start discards a non-empty partial or held word, and saturates at 0xFFFF.
  - Both counters clear on reset.
- Undefined: neither port nor its logic exists, and core behaviour is identical.

Decomposition:
- Shared package sobel_pkg holds:
  - PIX_W=8, PIX_PER_WORD=8, MAX_LINE_WIDTH=64, COL_IDX_W=7.
  - Packer FSM state enum {S_FILL, S_WAIT}.
  - The byte-slot ordering constant, shared with the Sobel engine.
- One sub-module, sobel_pack_word_buf: the output register with valid/ready, holding data and tags. The packer instantiates it once.

Test Plan:
- Continuous stream 0x00..0x3F with word_ready=1, LINE_WIDTH=64 -> first word dataa=0x03020100, datab=0x07060504, col_index=0, sol=1; 8th word dataa=0x3B3A3938, col_index=56, eol=1. No pix_ready deassertion.
- word_ready=0 for 20 cycles during a stream -> after 16 accepted pixels, pix_ready=0 and the FSM is in S_WAIT; the held word is unchanged. Releasing word_ready gives back-to-back words with no loss.
- Full frame, NUM_LINES=3 -> eof=1 only on word 24 (col_index=56). Word 25 has sol=1 with line_cnt back at 0.
- 5 pixels sent, then frame_start pulse with pixel 0xAA in the same cycle -> the next word has dataa[7:0]=0xAA, col_index=0, sol=1. With SOBEL_PACK_STATS_EN, drop_count=1.
- reset_n=0 for 1 cycle mid-line with word_valid=1 -> next cycle word_valid=0 and pix_ready=0; then pix_ready=1 and the first new word has col_index=0.
